// File: rtl/riscv_regfile_mp.sv
// riscv_regfile_mp: parametrised multi-port integer register file.
// NRD registered read ports (one-cycle latency, per-port valid strobe) and
// NWR write ports. When ports collide, the highest-indexed write port wins.
// Register 0 is hardwired to zero.
// Optional feature macro: RISCV_REGFILE_BYPASS_EN
//   defined   -> write-first: a same-cycle write is forwarded to the read.
//   undefined -> read-first: the read returns the pre-write value.
module riscv_regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD-1:0]        i_re,
  input  logic [NRD*$clog2(NREG)-1:0] i_raddr,
  input  logic [NWR-1:0]        i_we,
  input  logic [NWR*$clog2(NREG)-1:0] i_waddr,
  input  logic [NWR*XLEN-1:0]   i_wdata,
  output logic [NRD*XLEN-1:0]   o_rdata,
  output logic [NRD-1:0]        o_rvalid
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_r   [NREG];
  logic [AW-1:0]   raddr_s  [NRD];
  logic [AW-1:0]   waddr_s  [NWR];
  logic [XLEN-1:0] wdata_s  [NWR];
  logic [XLEN-1:0] rd_val_s [NRD];
  logic [NRD*XLEN-1:0] rdata_r;
  logic [NRD-1:0]      rvalid_r;

  // Unpack the flat port buses into per-port fields.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      raddr_s[p] = i_raddr[p*AW +: AW];
    end
    for (int w = 0; w < NWR; w++) begin
      waddr_s[w] = i_waddr[w*AW +: AW];
      wdata_s[w] = i_wdata[w*XLEN +: XLEN];
    end
  end

`ifdef RISCV_REGFILE_BYPASS_EN
  // Write-first read value: forward the same-cycle write, later ports override earlier ones.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      logic [XLEN-1:0] val_v;
      val_v = regs_r[raddr_s[p]];
      for (int w = 0; w < NWR; w++) begin
        val_v = (i_we[w] && (waddr_s[w] == raddr_s[p]) && (waddr_s[w] != {AW{1'b0}}))
                ? wdata_s[w] : val_v;
      end
      rd_val_s[p] = val_v;
    end
  end
`else
  // Read-first read value: the array contents before this edge's writes.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_val_s[p] = regs_r[raddr_s[p]];
    end
  end
`endif

  // Register array update; ascending port order lets the highest port win a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (i_we[w] && (waddr_s[w] != {AW{1'b0}})) begin
          regs_r[waddr_s[w]] <= wdata_s[w];
        end
      end
    end
  end

  // Registered read outputs; disabled ports and address 0 return zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r  <= {(NRD*XLEN){1'b0}};
      rvalid_r <= {NRD{1'b0}};
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if (i_re[p]) begin
          rvalid_r[p] <= 1'b1;
          rdata_r[p*XLEN +: XLEN] <= (raddr_s[p] == {AW{1'b0}}) ? {XLEN{1'b0}} : rd_val_s[p];
        end else begin
          rvalid_r[p] <= 1'b0;
          rdata_r[p*XLEN +: XLEN] <= {XLEN{1'b0}};
        end
      end
    end
  end

  assign o_rdata  = rdata_r;
  assign o_rvalid = rvalid_r;

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Self-checking bench for riscv_regfile_mp (2 read ports, 2 write ports).
// A behavioural register-array model predicts every output; directed
// literal checks pin the model and the spec's called-out corner cases.
module tb_riscv_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst;
  logic [NRD-1:0]       re;
  logic [NRD*AW-1:0]    raddr;
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    waddr;
  logic [NWR*XLEN-1:0]  wdata;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rvalid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  riscv_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_re     (re),
    .i_raddr  (raddr),
    .i_we     (we),
    .i_waddr  (waddr),
    .i_wdata  (wdata),
    .o_rdata  (rdata),
    .o_rvalid (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [NREG];
  logic [31:0] exp_rdata [NRD];
  logic [1:0]  exp_rvalid;
  bit          started = 1'b0;

  task automatic m_writes();
    for (int w = 0; w < NWR; w++) begin
      int a;
      a = int'(waddr[w*AW +: AW]);
      if (we[w] && a != 0) m_regs[a] = wdata[w*XLEN +: XLEN];
    end
  endtask

  task automatic m_reads();
    for (int p = 0; p < NRD; p++) begin
      int a;
      a = int'(raddr[p*AW +: AW]);
      exp_rvalid[p] = re[p];
      exp_rdata[p]  = (re[p] && a != 0) ? m_regs[a] : 32'h0;
    end
  endtask

  // Model advances on every rising edge from the inputs the DUT samples.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_regs[r] = 32'h0;
      for (int p = 0; p < NRD; p++) exp_rdata[p] = 32'h0;
      exp_rvalid = 2'b00;
      started = 1'b1;
    end else begin
`ifdef RISCV_REGFILE_BYPASS_EN
      m_writes();
      m_reads();
`else
      m_reads();
      m_writes();
`endif
    end
  end

  // Compare process: every falling edge once the first reset has been seen.
  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("model_rdata%0d", p), rdata[p*XLEN +: XLEN], exp_rdata[p]);
        chk($sformatf("model_rvalid%0d", p), {31'h0, rvalid[p]}, {31'h0, exp_rvalid[p]});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    re = 2'b00;
    we = 2'b00;
  endtask

  task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d);
    we[w] = 1'b1;
    waddr[w*AW +: AW] = a;
    wdata[w*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    re[p] = 1'b1;
    raddr[p*AW +: AW] = a;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    re = 2'b00; raddr = '0; we = 2'b00; waddr = '0; wdata = '0;

    // Reset held two cycles while a write and reads are presented.
    rst = 1'b1;
    wr(0, 5'd5, 32'hDEADBEEF); rd(0, 5'd5); rd(1, 5'd5);
    tick();
    chk("rst_rvalid_c1", {30'h0, rvalid}, 32'h0);
    chk("rst_rdata0_c1", rdata[31:0], 32'h0);
    tick();
    chk("rst_rvalid_c2", {30'h0, rvalid}, 32'h0);
    rst = 1'b0; idle(); rd(0, 5'd5);
    tick();
    chk("post_rst_x5", rdata[31:0], 32'h0);
    chk("post_rst_rvalid", {30'h0, rvalid}, 32'h1);

    // Basic write then read.
    idle(); wr(0, 5'd3, 32'h12345678);
    tick();
    idle(); rd(0, 5'd3); rd(1, 5'd0);
    tick();
    chk("basic_x3", rdata[31:0], 32'h12345678);
    chk("basic_x0", rdata[63:32], 32'h0);
    chk("basic_rvalid", {30'h0, rvalid}, 32'h3);
    chk("model_pin_x3", exp_rdata[0], 32'h12345678);

    // Zero register write dropped; port 1 disabled.
    idle(); wr(0, 5'd0, 32'hFFFFFFFF);
    tick();
    idle(); rd(0, 5'd0); raddr[9:5] = 5'd3;
    tick();
    chk("zero_x0", rdata[31:0], 32'h0);
    chk("rdis_rdata1", rdata[63:32], 32'h0);
    chk("rdis_rvalid", {30'h0, rvalid}, 32'h1);

    // Write priority, then distinct addresses.
    idle(); wr(0, 5'd7, 32'hAAAA0000); wr(1, 5'd7, 32'h0000BBBB);
    tick();
    idle(); wr(0, 5'd8, 32'h00000088); wr(1, 5'd9, 32'h00000099); rd(0, 5'd7);
    tick();
    chk("prio_x7", rdata[31:0], 32'h0000BBBB);
    chk("model_pin_x7", exp_rdata[0], 32'h0000BBBB);
    idle(); rd(0, 5'd8); rd(1, 5'd9);
    tick();
    chk("distinct_x8", rdata[31:0], 32'h00000088);
    chk("distinct_x9", rdata[63:32], 32'h00000099);

    // Same-cycle read/write hazard.
    idle(); wr(0, 5'd4, 32'h11);
    tick();
    idle(); wr(0, 5'd4, 32'h22); rd(0, 5'd4);
    tick();
`ifdef RISCV_REGFILE_BYPASS_EN
    chk("hazard_x4", rdata[31:0], 32'h22);
`else
    chk("hazard_x4", rdata[31:0], 32'h11);
`endif
    idle(); rd(0, 5'd4);
    tick();
    chk("hazard_next_x4", rdata[31:0], 32'h22);

    // Hazard cycle with reset asserted.
    idle(); wr(0, 5'd4, 32'h11);
    tick();
    idle(); rst = 1'b1; wr(0, 5'd4, 32'h22); rd(0, 5'd4);
    tick();
    chk("hzrst_rvalid", {30'h0, rvalid}, 32'h0);
    chk("hzrst_rdata", rdata[31:0], 32'h0);
    rst = 1'b0; idle(); rd(0, 5'd4);
    tick();
    chk("hzrst_x4", rdata[31:0], 32'h0);
    chk("hzrst_rvalid_after", {30'h0, rvalid}, 32'h1);

    // Randomized traffic; narrow address range half the time to force collisions.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      re  = 2'($urandom);
      we  = 2'($urandom);
      for (int p = 0; p < NRD; p++)
        raddr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      for (int w = 0; w < NWR; w++) begin
        waddr[w*AW +: AW] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        wdata[w*XLEN +: XLEN] = $urandom;
      end
      tick();
    end

    rst = 1'b0; idle();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_mp.md
Name: riscv_regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core.
- Generalises the fixed 2R/1W 32x32 register file to:
  - configurable data width, register count, read-port count and write-port count;
  - registered reads with a valid strobe;
  - deterministic write-port priority;
  - optional write-to-read bypass.
- Sits between decode (read ports) and writeback (write ports).
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two, >= 2).
- NRD, 2, number of read ports (>= 1).
- NWR, 1, number of write ports (>= 1).
- AW, $clog2(NREG), address width (localparam, derived; not overridable).

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  reset; synchronous, active-high.
- i_re  input  NRD  per-port read enable.
- i_raddr  input  NRD*AW  read addresses; port p occupies bits [p*AW +: AW].
- i_we  input  NWR  per-port write enable.
- i_waddr  input  NWR*AW  write addresses; port w occupies bits [w*AW +: AW].
- i_wdata  input  NWR*XLEN  write data; port w occupies bits [w*XLEN +: XLEN].
- o_rdata  output  NRD*XLEN  read data; port p occupies bits [p*XLEN +: XLEN].
- o_rvalid  output  NRD  per-port read valid.

Behaviour:
- Reset
  - Interface: one clock; reset is synchronous and active-high.
  - On a clk edge with rst=1, all NREG registers clear to 0, o_rdata clears to 0 and o_rvalid clears to 0.
  - Reset dominates: writes and reads presented in the reset cycle are discarded.
  - Reset asserted mid-operation discards the in-flight read; the next cycle shows o_rvalid=0.
- Reads (latency 1)
  - Port p samples i_re[p] and i_raddr[p] at edge N.
  - o_rdata[p] and o_rvalid[p] update at edge N+1 and hold until the next edge.
  - If i_re[p]=0: o_rdata[p]=0 and o_rvalid[p]=0.
  - If i_re[p]=1 and raddr=0: o_rdata[p]=0 and o_rvalid[p]=1.
  - Otherwise o_rdata[p] = contents of the addressed register, with o_rvalid[p]=1.
  - All read ports are independent; several ports may read the same address.
- Writes
  - At a clk edge, each port w with i_we[w]=1 and waddr != 0 writes i_wdata[w] into regs[waddr].
  - A write to address 0 is silently dropped; regs[0] always reads 0.
  - If several ports write the same address in one cycle, the highest-indexed port wins; lower-indexed ports to that address are ignored.
  - Writes to distinct addresses in the same cycle all commit.
- Read/write same cycle, same nonzero address
  - Behaviour is governed by the optional feature below.
  - A write in cycle N is always visible to any read sampled in cycle N+1 or later.
- Arithmetic/width
  - No arithmetic is performed; data is passed through unmodified at XLEN bits.
  - Address compares use the full AW bits.
- No X propagation
  - Unused address bits with NREG a power of two cannot occur.
  - Outputs must never be X after the first reset.

Optional Feature:
- Macro: RISCV_REGFILE_BYPASS_EN
- Defined (write-first):
  - A read sampled in the same cycle as a write to the same nonzero address returns the new i_wdata at N+1.
  - The forwarded value follows the same highest-port-wins priority as the write.
  - Reads of address 0 still return 0.
- Undefined (read-first):
  - The read returns the pre-write register value.
  - The new value is visible from the following read onward.
  - External forwarding logic is then responsible for the hazard.

Test Plan:
- Reset: hold rst=1 for 2 cycles while driving i_we[0]=1, waddr=5, wdata=0xDEADBEEF; release, then read addr 5 -> 0x00000000, o_rvalid=1; all o_rvalid=0 during reset.
- Basic write/read:
  - Write 0x12345678 to x3, then read x3 on port 0 and x0 on port 1 the next cycle.
  - One cycle later: port 0 = 0x12345678, port 1 = 0, both valid.
- Zero register: write 0xFFFFFFFF to x0, then read x0 -> 0, o_rvalid=1.
- Read disable: i_re=2'b01 with raddr1=3 -> o_rdata port 1 = 0 and o_rvalid=2'b01.
- Write priority (NWR=2):
  - Same cycle: port 0 writes x7=0xAAAA0000 and port 1 writes x7=0x0000BBBB.
  - Subsequent read of x7 -> 0x0000BBBB.
  - Distinct addresses x8/x9 both commit.
- Same-cycle hazard:
  - Setup: x4=0x11, then same cycle write x4=0x22 and read x4.
  - With RISCV_REGFILE_BYPASS_EN: read data = 0x22.
  - Without it: read data = 0x11, next read = 0x22.
  - Repeat with rst asserted in the hazard cycle -> x4=0 and o_rvalid=0.
